// File: rtl/io_port.sv
// io_port: CPU load/store port at data address 0, bridging to a TX FIFO toward
// an external device and an RX FIFO from it, both with ready/valid handshakes.
`default_nettype none

module io_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)
      count_d = count_q + CW'(1);
    else if (!push_i && pop_i)
      count_d = count_q - CW'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

module io_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            cpu_addr,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [WIDTH-1:0]       cpu_wdata,
  output logic [WIDTH-1:0]       cpu_rdata,
  output logic                   cpu_stall,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count
);
  logic             sel, cpu_wr, cpu_rd;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [WIDTH-1:0] tx_head, rx_head;

  assign sel    = (cpu_addr == 16'd0);
  assign cpu_wr = sel & cpu_we;
  // A simultaneous store and load is a store only.
  assign cpu_rd = sel & cpu_re & ~cpu_we;

  // Full/empty come from registered counts: no same-cycle bypass either way.
  assign tx_push = cpu_wr & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_push = rx_valid & rx_ready;
  assign rx_pop  = cpu_rd & ~rx_empty;

  io_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (cpu_wdata),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  io_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_data),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // Heads are masked so unwritten storage never reaches an output.
  assign tx_valid  = ~tx_empty;
  assign tx_data   = tx_valid ? tx_head : '0;
  assign rx_ready  = reset_n & ~rx_full;
  assign cpu_rdata = rx_pop ? rx_head : '0;
  assign cpu_stall = reset_n & ((cpu_wr & tx_full) | (cpu_rd & rx_empty));
endmodule

`default_nettype wire

// File: tb/tb_io_port.sv
// tb_io_port: vector table with explicit expectations plus a queue scoreboard
// for TX/RX word order, and a hand-written mid-operation reset sequence.
`default_nettype none

module tb_io_port;
  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   cpu_addr;
  logic          cpu_we, cpu_re;
  logic [W-1:0]  cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic [W-1:0]  tx_data;
  logic          tx_valid, tx_ready;
  logic [W-1:0]  rx_data;
  logic          rx_valid, rx_ready;
  logic [2:0]    tx_count, rx_count;

  always #5 clk = ~clk;

  io_port #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_count  (tx_count),
    .rx_count  (rx_count)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic        re;
    logic [15:0] wd;
    logic        txr;
    logic        rxv;
    logic [15:0] rxd;
    logic        stall;
    logic [15:0] rdata;
    logic        txv;
    logic [15:0] txd;
    logic [2:0]  txc;
    logic [2:0]  rxc;
    logic        rxr;
  } vec_t;

  vec_t        vt[$];
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  function automatic vec_t V(input int addr, input int we, input int re, input int wd,
                             input int txr, input int rxv, input int rxd,
                             input int st, input int rd, input int txv, input int txd,
                             input int txc, input int rxc, input int rxr);
    vec_t v;
    v = '{16'(addr), 1'(we), 1'(re), 16'(wd), 1'(txr), 1'(rxv), 16'(rxd),
          1'(st), 16'(rd), 1'(txv), 16'(txd), 3'(txc), 3'(rxc), 1'(rxr)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one vector just after an edge, check mid-cycle, update the model, advance.
  task automatic apply(input int idx);
    vec_t v;
    bit   sel, tx_acc, tx_deq, rx_acc, rx_deq, m_stall;
    v = vt[idx];
    cpu_addr = v.addr; cpu_we = v.we; cpu_re = v.re; cpu_wdata = v.wd;
    tx_ready = v.txr; rx_valid = v.rxv; rx_data = v.rxd;
    #4;
    chk($sformatf("v%0d_stall", idx), 32'(cpu_stall), 32'(v.stall));
    chk($sformatf("v%0d_rdata", idx), 32'(cpu_rdata), 32'(v.rdata));
    chk($sformatf("v%0d_tx_valid", idx), 32'(tx_valid), 32'(v.txv));
    if (v.txv) chk($sformatf("v%0d_tx_data", idx), 32'(tx_data), 32'(v.txd));
    chk($sformatf("v%0d_tx_count", idx), 32'(tx_count), 32'(v.txc));
    chk($sformatf("v%0d_rx_count", idx), 32'(rx_count), 32'(v.rxc));
    chk($sformatf("v%0d_rx_ready", idx), 32'(rx_ready), 32'(v.rxr));

    sel     = (v.addr == 16'd0);
    tx_acc  = sel && v.we && (txq.size() < D);
    tx_deq  = (txq.size() != 0) && v.txr;
    rx_acc  = v.rxv && (rxq.size() < D);
    rx_deq  = sel && v.re && !v.we && (rxq.size() != 0);
    m_stall = sel && ((v.we && txq.size() == D) || (v.re && !v.we && rxq.size() == 0));
    chk($sformatf("sb%0d_tx_valid", idx), 32'(tx_valid), 32'(txq.size() != 0));
    chk($sformatf("sb%0d_stall", idx), 32'(cpu_stall), 32'(m_stall));
    chk($sformatf("sb%0d_counts", idx), {26'd0, tx_count, rx_count},
        {26'd0, 3'(txq.size()), 3'(rxq.size())});
    if (tx_deq) chk($sformatf("sb%0d_tx_order", idx), 32'(tx_data), 32'(txq.pop_front()));
    if (rx_deq) chk($sformatf("sb%0d_rx_order", idx), 32'(cpu_rdata), 32'(rxq.pop_front()));
    if (tx_acc) txq.push_back(v.wd);
    if (rx_acc) rxq.push_back(v.rxd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_re = 1'b1; cpu_wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

    // CPU store path, then tx_ready drains in order
    vt.push_back(V(0,1,0,16'h1234,0,0,0, 0,0,0,0,0,0,1));
    vt.push_back(V(0,1,0,16'hBEEF,0,0,0, 0,0,1,16'h1234,1,0,1));
    vt.push_back(V(0,0,0,0,0,0,0,        0,0,1,16'h1234,2,0,1));
    vt.push_back(V(0,0,0,0,1,0,0,        0,0,1,16'h1234,2,0,1));
    vt.push_back(V(0,0,0,0,1,0,0,        0,0,1,16'hBEEF,1,0,1));
    vt.push_back(V(0,0,0,0,0,0,0,        0,0,0,0,0,0,1));
    // TX full: fifth store stalls, full FIFO refuses even while popping
    vt.push_back(V(0,1,0,1,0,0,0,        0,0,0,0,0,0,1));
    vt.push_back(V(0,1,0,2,0,0,0,        0,0,1,1,1,0,1));
    vt.push_back(V(0,1,0,3,0,0,0,        0,0,1,1,2,0,1));
    vt.push_back(V(0,1,0,4,0,0,0,        0,0,1,1,3,0,1));
    vt.push_back(V(0,1,0,16'h5555,0,0,0, 1,0,1,1,4,0,1));
    vt.push_back(V(0,1,0,16'h5555,0,0,0, 1,0,1,1,4,0,1));
    vt.push_back(V(0,1,0,16'h5555,1,0,0, 1,0,1,1,4,0,1));
    vt.push_back(V(0,1,0,16'h5555,0,0,0, 0,0,1,2,3,0,1));
    vt.push_back(V(0,0,0,0,1,0,0,        0,0,1,2,4,0,1));
    vt.push_back(V(0,0,0,0,1,0,0,        0,0,1,3,3,0,1));
    vt.push_back(V(0,0,0,0,1,0,0,        0,0,1,4,2,0,1));
    vt.push_back(V(0,0,0,0,1,0,0,        0,0,1,16'h5555,1,0,1));
    vt.push_back(V(0,0,0,0,0,0,0,        0,0,0,0,0,0,1));
    // RX path: empty load stalls, no same-cycle forwarding
    vt.push_back(V(0,0,1,0,0,0,0,        1,0,0,0,0,0,1));
    vt.push_back(V(0,0,1,0,0,1,16'h00A5, 1,0,0,0,0,0,1));
    vt.push_back(V(0,0,1,0,0,0,0,        0,16'h00A5,0,0,0,1,1));
    vt.push_back(V(0,0,0,0,0,0,0,        0,0,0,0,0,0,1));
    // RX full and pointer wrap
    vt.push_back(V(0,0,0,0,0,1,1,        0,0,0,0,0,0,1));
    vt.push_back(V(0,0,0,0,0,1,2,        0,0,0,0,0,1,1));
    vt.push_back(V(0,0,0,0,0,1,3,        0,0,0,0,0,2,1));
    vt.push_back(V(0,0,0,0,0,1,4,        0,0,0,0,0,3,1));
    vt.push_back(V(0,0,0,0,0,1,5,        0,0,0,0,0,4,0));
    vt.push_back(V(0,0,0,0,0,1,5,        0,0,0,0,0,4,0));
    vt.push_back(V(0,0,1,0,0,1,5,        0,1,0,0,0,4,0));
    vt.push_back(V(0,0,1,0,0,1,5,        0,2,0,0,0,3,1));
    vt.push_back(V(0,0,1,0,0,1,6,        0,3,0,0,0,3,1));
    vt.push_back(V(0,0,1,0,0,0,0,        0,4,0,0,0,3,1));
    vt.push_back(V(0,0,1,0,0,0,0,        0,5,0,0,0,2,1));
    vt.push_back(V(0,0,1,0,0,0,0,        0,6,0,0,0,1,1));
    vt.push_back(V(0,0,0,0,0,0,0,        0,0,0,0,0,0,1));
    // Non-selected address, then store+load conflict
    vt.push_back(V(16'h0010,1,0,16'h7777,0,0,0, 0,0,0,0,0,0,1));
    vt.push_back(V(16'h0010,0,1,0,0,0,0,        0,0,0,0,0,0,1));
    vt.push_back(V(0,0,0,0,0,1,16'h0042,        0,0,0,0,0,0,1));
    vt.push_back(V(0,1,1,16'h0099,0,0,0,        0,0,0,0,0,1,1));
    vt.push_back(V(0,0,0,0,0,0,0,               0,0,1,16'h0099,1,1,1));
    // Fill to tx_count=3, rx_count=2 ahead of the reset
    vt.push_back(V(0,1,0,16'hAAAA,0,1,16'h0043, 0,0,1,16'h0099,1,1,1));
    vt.push_back(V(0,1,0,16'hBBBB,0,0,0,        0,0,1,16'h0099,2,2,1));
    vt.push_back(V(0,0,0,0,0,0,0,               0,0,1,16'h0099,3,2,1));
    // After reset: nothing stale, load stalls, 1-cycle store-to-device latency
    vt.push_back(V(0,0,0,0,1,0,0,               0,0,0,0,0,0,1));
    vt.push_back(V(0,0,1,0,0,0,0,               1,0,0,0,0,0,1));
    vt.push_back(V(0,1,0,16'h0F0F,1,0,0,        0,0,0,0,0,0,1));
    vt.push_back(V(0,0,0,0,1,0,0,               0,0,1,16'h0F0F,1,0,1));
    vt.push_back(V(0,0,0,0,0,0,0,               0,0,0,0,0,0,1));

    #10;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_counts", {26'd0, tx_count, rx_count}, 32'd0);
    #2;
    reset_n = 1'b1; cpu_re = 1'b0;
    #1;
    chk("rel_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 44; i++) apply(i);

    // Reset pulse between edges with both FIFOs occupied
    cpu_addr = '0; cpu_re = 1'b1; cpu_we = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    #1;
    chk("pre_rst_tx_count", 32'(tx_count), 32'd3);
    chk("pre_rst_rx_count", 32'(rx_count), 32'd2);
    chk("pre_rst_rdata", 32'(cpu_rdata), 32'h0042);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
    chk("mid_rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("mid_rst_counts", {26'd0, tx_count, rx_count}, 32'd0);
    cpu_re = 1'b0;
    txq.delete();
    rxq.delete();
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 44; i < vt.size(); i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/io_port.md
IO_PORT -- requirements
Module: io_port

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of the CPU, TX and RX data paths.
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count of each FIFO (TX and RX); DEPTH SHALL be a power of two, 2 or greater.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 cpu_addr  input  16  SHALL be the CPU data-memory address; the port is selected when cpu_addr == 0.
REQ-006 cpu_we  input  1  SHALL be the CPU store strobe.
REQ-007 cpu_re  input  1  SHALL be the CPU load strobe.
REQ-008 cpu_wdata  input  WIDTH  SHALL be the store data presented at address 0.
REQ-009 cpu_rdata  output  WIDTH  SHALL be the load data returned for address 0.
REQ-010 cpu_stall  output  1  SHALL request a CPU stall when an address-0 access cannot complete this cycle.
REQ-011 tx_data  output  WIDTH  SHALL be the TX FIFO head toward the external device.
REQ-012 tx_valid  output  1  SHALL indicate that tx_data holds a valid word.
REQ-013 tx_ready  input  1  SHALL be the device acceptance of tx_data.
REQ-014 rx_data  input  WIDTH  SHALL be the word offered by the device.
REQ-015 rx_valid  input  1  SHALL indicate that rx_data is valid.
REQ-016 rx_ready  output  1  SHALL indicate that the RX FIFO can accept a word.
REQ-017 tx_count, rx_count  output  log2(DEPTH)+1 each  SHALL report the current FIFO occupancy.

Function
REQ-018 sel SHALL equal (cpu_addr == 0); with sel low, the block SHALL ignore cpu_we and cpu_re, hold cpu_stall at 0 and drive cpu_rdata at 0.
REQ-019 CPU write: when sel & cpu_we & tx_count < DEPTH, cpu_wdata SHALL be pushed to the TX tail at the clock edge.
  - If the TX FIFO is full, there SHALL be no push and cpu_stall SHALL be 1 (combinational).
REQ-020 CPU read: when sel & cpu_re & !cpu_we, cpu_rdata SHALL combinationally equal the RX head whenever rx_count > 0.
  - The RX head SHALL be popped at that edge.
  - If the RX FIFO is empty, cpu_rdata SHALL be 0, there SHALL be no pop, and cpu_stall SHALL be 1.
REQ-021 cpu_we and cpu_re both high SHALL be treated as a write only; the read SHALL be ignored.
REQ-022 tx_valid SHALL be (tx_count != 0), and tx_data SHALL be the TX head.
  - The TX head SHALL be popped at the edge where tx_valid & tx_ready.
  - tx_data SHALL be held stable while tx_valid & !tx_ready.
REQ-023 rx_ready SHALL be reset_n & (rx_count < DEPTH); the RX FIFO SHALL push rx_data at the edge where rx_valid & rx_ready.
REQ-024 Full/empty decisions SHALL use the registered counts only; there SHALL be no bypass from push to pop in the same cycle.
  - A full FIFO SHALL refuse a push even while it pops in the same cycle.
  - An empty FIFO SHALL not forward an input word in the same cycle.
REQ-025 A simultaneous push and pop on a FIFO that is neither full nor empty SHALL leave its count unchanged and advance both pointers.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; counts SHALL saturate at neither 0 nor DEPTH, because REQ-019, REQ-020, REQ-023 and REQ-024 make over/underflow impossible.
REQ-027 Latency:
  - A word pushed at edge N SHALL be visible at the FIFO head (tx_data or cpu_rdata) from edge N onward, i.e. in the following cycle.
  - The minimum CPU-to-device latency SHALL be 1 cycle.
REQ-028 Words SHALL leave each FIFO in strict arrival order; there SHALL be no drop or duplication.

Reset
REQ-029 While reset_n is low, the block SHALL asynchronously clear all pointers and counts.
  - tx_valid SHALL be 0, rx_ready SHALL be 0, cpu_stall SHALL be 0, cpu_rdata SHALL be 0, and tx_count and rx_count SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard all FIFO contents; no stale word SHALL appear after release.
REQ-031 After reset_n rises, rx_ready SHALL be 1 and the first push SHALL be accepted at the next clock edge.
REQ-032 FIFO storage contents SHALL not require a reset value; no output SHALL expose unwritten storage.

Verification
REQ-033 CPU store path: store 0x1234 then 0xBEEF to address 0 with tx_ready = 0 -> tx_valid = 1 and tx_data = 0x1234 and tx_count = 2 with tx_ready = 0; raise tx_ready -> 0x1234 then 0xBEEF on consecutive cycles, then tx_valid = 0.
REQ-034 TX full: 4 stores with tx_ready = 0, then a fifth store of 0x5555 -> cpu_stall = 1, tx_count stays 4; one tx_ready pulse -> the next cycle accepts 0x5555 and cpu_stall = 0.
REQ-035 RX path: load from address 0 with the RX FIFO empty -> cpu_stall = 1 and cpu_rdata = 0; device pushes 0x00A5 -> the load completes with cpu_rdata = 0x00A5 and rx_count returns to 0.
REQ-036 RX full and wrap: the device pushes 6 words 1..6 with no loads -> rx_ready = 0 after 4 pushes, and words 5 and 6 are held by the device; 6 loads -> returns 1,2,3,4,5,6 in order across the pointer wrap.
REQ-037 Non-selected address and conflict:
  - store to address 0x0010 -> no TX push and cpu_stall = 0.
  - cpu_we and cpu_re both high at address 0 with rx_count = 1 -> TX push only, rx_count stays 1.
REQ-038 Reset mid-operation: with tx_count = 3 and rx_count = 2, pulse reset_n low between clock edges -> all outputs clear immediately; after release, tx_valid = 0 and a load stalls.
